// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-to-1 streaming multiplexer.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Index width that never collapses to zero bits, even for a single channel.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr, wraps
// modulo N, and grants the first requesting channel.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  // Walk the candidates from farthest to nearest so the nearest requester wins.
  always_comb begin
    int c;
    c         = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (req[c]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/mux_nx1_stream.sv
// N-to-1 streaming multiplexer with a single registered output stage.
// Channel choice is an external select (direct mode) or a fair round-robin.
module mux_nx1_stream
  import mux_pkg::*;
#(
  parameter  int N_INPUTS = 4,
  parameter  int WIDTH    = 8,
  localparam int SEL_W    = clog2_min1(N_INPUTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_INPUTS*WIDTH-1:0] in_data,
  input  logic [N_INPUTS-1:0]       in_valid,
  output logic [N_INPUTS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] chan_data [N_INPUTS];
  logic [SEL_W-1:0] rr_ptr;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_idx;
  logic             dir_valid;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic             load_en;
  logic             xfer;

  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] chan_p1;
  logic             vld_p1;

  rr_arbiter #(
    .N     (N_INPUTS),
    .SEL_W (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // Unpack the flat input bus into per-channel words.
  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) begin
      chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Out-of-range selects yield no grant at all.
  assign dir_valid = ({1'b0, sel} < (SEL_W+1)'(N_INPUTS));

  // Grant selection, ready generation and transfer detection. The output
  // register accepts when empty or draining, so out_ready reaches in_ready
  // combinationally on purpose.
  always_comb begin
    grant_valid = (mode == MODE_RR) ? rr_valid : dir_valid;
    grant_idx   = (mode == MODE_RR) ? rr_idx   : sel;
    load_en     = !vld_p1 || out_ready;
    in_ready    = '0;
    if (!rst && grant_valid && load_en) begin
      in_ready[grant_idx] = 1'b1;
    end
    xfer = !rst && grant_valid && load_en && in_valid[grant_idx];
  end

  // ---- stage p1: output register and round-robin pointer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      chan_p1 <= '0;
      rr_ptr  <= SEL_W'(N_INPUTS - 1);
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= chan_data[grant_idx];
      chan_p1 <= grant_idx;
      if (mode == MODE_RR) rr_ptr <= grant_idx;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_data  = data_p1;
  assign out_valid = vld_p1;
  assign out_chan  = chan_p1;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Self-checking bench for mux_nx1_stream (N_INPUTS=4, WIDTH=8).
module tb_mux_nx1_stream;

  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [S-1:0]   sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [S-1:0]   out_chan;
  logic           out_ready;

  int vectors = 0;
  int errors  = 0;

  // model state
  logic [S+W-1:0] sb_q [$];
  logic           m_valid;
  logic           m_known;
  int             m_ptr;

  mux_nx1_stream #(.N_INPUTS(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic set_data(input int ch, input logic [W-1:0] v);
    in_data[ch*W +: W] = v;
  endtask

  // One clock: check combinational outputs and scoreboard at the negedge,
  // advance the model, then step past the rising edge.
  task automatic cycle();
    bit          g_ok;
    int          g;
    bit          load;
    logic [N-1:0] exp_ready;
    logic [S+W-1:0] front;
    @(negedge clk);
    g_ok = 1'b0;
    g    = 0;
    if (mode == 1'b0) begin
      g_ok = (int'(sel) < N);
      g    = int'(sel);
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (!g_ok && in_valid[(m_ptr + k) % N]) begin
          g_ok = 1'b1;
          g    = (m_ptr + k) % N;
        end
      end
    end
    load      = !m_valid || out_ready;
    exp_ready = '0;
    if (!rst && g_ok && load) exp_ready[g] = 1'b1;
    vectors++;
    if (in_ready !== exp_ready) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_ready, $time);
    end
    if (m_known) begin
      vectors++;
      if (out_valid !== m_valid) begin
        errors++;
        $display("FAIL out_valid: got %b expected %b at %0t", out_valid, m_valid, $time);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        vectors++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got chan %0d data %h expected no word", out_chan, out_data);
        end else begin
          front = sb_q.pop_front();
          if ({out_chan, out_data} !== front) begin
            errors++;
            $display("FAIL sb_word: got chan %0d data %h expected chan %0d data %h",
                     out_chan, out_data, front[S+W-1:W], front[W-1:0]);
          end
        end
      end
    end
    if (rst) begin
      m_valid = 1'b0;
      m_ptr   = N - 1;
      sb_q.delete();
    end else if (exp_ready != 0 && in_valid[g]) begin
      sb_q.push_back({S'(g), in_data[g*W +: W]});
      m_valid = 1'b1;
      if (mode == 1'b1) m_ptr = g;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    if (rst) m_known = 1'b1;
    #1;
  endtask

  task automatic check_out(input string name, input logic v, input logic [W-1:0] d,
                           input logic [S-1:0] c);
    vectors++;
    if (out_valid !== v || out_data !== d || out_chan !== c) begin
      errors++;
      $display("FAIL %s: got v=%b d=%h c=%0d expected v=%b d=%h c=%0d",
               name, out_valid, out_data, out_chan, v, d, c);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; mode = 1'b1; sel = '0;
    for (int i = 0; i < N; i++) set_data(i, W'(8'h50 + i));
    for (int i = 0; i < 2; i++) begin
      cycle();
      check_out("reset_state", 1'b0, 8'h00, 2'd0);
    end
    rst = 1'b0; in_valid = '0;
  endtask

  task automatic test_direct();
    mode = 1'b0; sel = 2'd2; set_data(2, 8'hA5); in_valid = 4'b0100; out_ready = 1'b1;
    cycle();
    check_out("direct_load", 1'b1, 8'hA5, 2'd2);
    sel = 2'd3;
    cycle();
    check_out("direct_nogrant", 1'b0, 8'hA5, 2'd2);
    in_valid = '0;
  endtask

  task automatic test_rr_fair();
    logic [W-1:0] exp_d [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_data(i, W'(8'h10 + i));
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_out("rr_fair", 1'b1, exp_d[k], S'(k % N));
    end
    in_valid = '0;
    cycle();
  endtask

  task automatic test_rr_skip();
    in_valid = 4'b0010;
    cycle();
    in_valid = '0;
    cycle();
    in_valid = 4'b1010;
    cycle();
    check_out("rr_skip_first", 1'b1, 8'h13, 2'd3);
    cycle();
    check_out("rr_skip_second", 1'b1, 8'h11, 2'd1);
    in_valid = '0;
    cycle();
  endtask

  task automatic test_back_pressure();
    mode = 1'b0; sel = 2'd0; set_data(0, 8'h3C); in_valid = 4'b0001; out_ready = 1'b1;
    cycle();
    check_out("bp_load", 1'b1, 8'h3C, 2'd0);
    set_data(0, 8'h10);
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_out("bp_hold", 1'b1, 8'h3C, 2'd0);
    end
    out_ready = 1'b1;
    cycle();
    check_out("bp_release", 1'b1, 8'h12, 2'd2);
    in_valid = '0;
    cycle();
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    cycle();
    check_out("mid_load", 1'b1, 8'h13, 2'd3);
    in_valid = '0; out_ready = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    check_out("mid_reset", 1'b0, 8'h00, 2'd0);
    rst = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    cycle();
    check_out("mid_first", 1'b1, 8'h10, 2'd0);
    in_valid = '0;
    cycle();
    vectors++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d words expected 0", sb_q.size());
    end
  endtask

  initial begin
    m_valid = 1'b0; m_known = 1'b0; m_ptr = N - 1;
    in_data = '0;
    test_reset();
    test_direct();
    test_rr_fair();
    test_rr_skip();
    test_back_pressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mux_nx1_stream.md
Name: mux_nx1_stream

Overview:
Parametrised N-to-1 streaming multiplexer. It is the successor to the team's combinational 2x1 mux. Each input channel carries WIDTH-bit data with a valid/ready handshake. A single registered output stage drives a valid/ready downstream interface. Channel choice is either an external select (direct mode) or a fair round-robin arbiter. The block sits between several producers and one consumer where back-pressure and fairness matter.

Parameters:
N_INPUTS, 4, number of input channels (2..16)
WIDTH, 8, data width per channel
SEL_W, $clog2(N_INPUTS), localparam, width of select and channel-index fields

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_data  input  N_INPUTS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N_INPUTS  per-channel valid
in_ready  output  N_INPUTS  per-channel ready (at most one bit set)
mode  input  1  0 = direct select, 1 = round-robin
sel  input  SEL_W  channel chosen in direct mode
out_data  output  WIDTH  registered output data
out_valid  output  1  registered output valid
out_chan  output  SEL_W  index of the channel that produced out_data
out_ready  input  1  downstream ready

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_chan=0, rr_ptr=N_INPUTS-1, so channel 0 has first priority.
- in_ready is forced to all zeros while rst=1.
- Output stage has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- load_en = !out_valid || out_ready. This is a combinational path from out_ready to in_ready, which is intentional.
- Grant rules:
  - Direct mode: grant = sel when sel < N_INPUTS. Otherwise there is no grant.
  - RR mode: search starts at rr_ptr+1, wraps modulo N_INPUTS, and takes the first channel with in_valid set. With no valid input there is no grant.
- in_ready[grant] = load_en. All other in_ready bits are 0. in_ready does not depend on in_valid of the granted channel in direct mode.
- Transfer: occurs when in_valid[g] && in_ready[g]. On the next edge, out_data <= channel g data, out_chan <= g, out_valid <= 1. In RR mode, rr_ptr <= g.
- Latency: one cycle from input handshake to out_valid.
- Full throughput: with out_ready held at 1, one word is accepted per cycle.
- Drain: when out_ready=1 and no transfer occurs, out_valid <= 0. out_data and out_chan hold their last values.
- Hold: when out_valid=1 and out_ready=0, out_data, out_valid and out_chan are stable, and in_ready is all zeros.
- rr_ptr is updated only on a transfer in RR mode. Direct-mode transfers leave it unchanged.
- mode and sel are sampled combinationally each cycle. Changing them never alters a word already held in the output register.
- Reset mid-operation: a held word is discarded (out_valid=0 the cycle after rst) and rr_ptr is reinitialised.
- Simultaneous drain and load in the same cycle: the new word replaces the old one. There is no bubble and no duplication.

Decomposition:
- Package mux_pkg: MODE_DIRECT=1'b0, MODE_RR=1'b1, and a function clog2_min1 (returns 1 for N=1).
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], ptr[SEL_W].
  - Outputs: gnt_valid and gnt_idx[SEL_W].
  - Purely combinational rotate / priority-encode / rotate-back.
- The top level owns the output register, rr_ptr, the direct-select path and the in_ready generation.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1111 and out_ready=1 -> in_ready=0000, out_valid=0, out_data=00, out_chan=0. Keeping out_valid=0 and in_ready=0000 throughout reset confirms no transfer occurs during rst=1.
- Direct mode: mode=0, sel=2, channel 2 data=A5, in_valid=0100, out_ready=1 -> in_ready=0100. Next cycle out_valid=1, out_data=A5, out_chan=2. With sel=3 and in_valid=0100 -> no transfer.
- RR fairness: mode=1, in_valid=1111, channel i data=10+i, out_ready=1 for 5 cycles -> out_data sequence 10,11,12,13,10 on consecutive cycles, out_chan 0,1,2,3,0.
- RR skip: rr_ptr=1, in_valid=1010 -> channel 3 is granted first, then channel 1. out_data 13, then 11.
- Back-pressure: out_valid=1 with out_data=3C, then out_ready=0 for 3 cycles while in_valid=1111 -> out_data stays 3C and in_ready=0000. Raise out_ready -> the next word appears one cycle later. The scoreboard shows no loss or duplication.
- Reset mid-operation: out_valid=1, out_ready=0, rst pulsed for 1 cycle -> out_valid=0 on the next cycle. Under RR with in_valid=1111, the first output after reset is from channel 0.
